roll_display_buffer: RTL and testbench
======================================

# roll_display_buffer

Circular column buffer that sits directly downstream of the roll-mode decimator. It captures each decimated 12-bit sample on its write strobe and serves the display scanner one column at a time, converted to a screen row. The newest sample is always drawn at the right edge and the trace scrolls left. The write base is latched per frame so that a frame never tears.

## Interface
Parameters:
- `DEPTH`, 640: number of display columns / buffer slots.
- `SAMPLE_W`, 12: sample width.
- `ROWS`, 480: visible rows; row 0 is the top of the screen.

Ports:
- `clk` input, 1: system clock.
- `rst_n` input, 1: reset. Synchronous, active-low.
- `sample_in` input, SAMPLE_W: decimated sample from the roll stage.
- `sample_we` input, 1: one-cycle write strobe, paired with `sample_in`.
- `freeze` input, 1: when 1, write strobes are ignored (hold the trace).
- `frame_start` input, 1: one-cycle pulse at the start of a frame; latches the read base.
- `rd_req` input, 1: column read request.
- `rd_col` input, 10: requested column, 0 = left edge.
- `rd_valid` output, 1: read response strobe.
- `rd_row` output, 9: screen row of the requested column's sample.
- `rd_blank` output, 1: column has no sample; the pixel column must be drawn empty.
- `full` output, 1: DEPTH samples have been captured since reset.

## Operation
- **Write side.** On `sample_we=1` with `freeze=0`:
  - RAM[wr_ptr] ← `sample_in`.
  - `wr_ptr` ← `wr_ptr`+1, wrapping from DEPTH-1 to 0.
  - `count` ← min(`count`+1, DEPTH).
- **Full flag.** `full` = (`count` == DEPTH); it stays set until reset.
- **Frame latch.** On `frame_start`, latch `base` ← `wr_ptr` and `fcount` ← `count`. All reads use the latched values. If a write and `frame_start` occur in the same cycle, the latch takes the pre-write values.
- **Read address.** `addr` = `base` + `rd_col`, minus DEPTH if the sum is ≥ DEPTH. The sum is 11 bits wide; a single conditional subtract is sufficient.
- **Blanking.** `rd_blank`=1 when `rd_col` ≥ DEPTH or `rd_col` < DEPTH − `fcount`. This right-aligns a partially filled buffer.
- **Scaling.** `rd_row` = ((2^SAMPLE_W − 1 − sample) × ROWS) >> SAMPLE_W.
  - The product is 22 bits with default parameters.
  - Value 0 maps to row 479; value 4095 maps to row 0.
  - When `rd_blank`=1, `rd_row` = 0.
- **RAM.** Simple dual-port, read-first. A read and a write to the same slot in the same cycle return the old data.
- **Reset.** Resets `wr_ptr`, `base`, `count` and `fcount` to 0. RAM contents are not cleared; the `count`/`fcount` blanking hides stale slots.

## Timing
- Read pipeline is 3 stages, fixed latency 3. A `rd_req` at cycle T produces `rd_valid`=1 at T+3.
  - T+1: address and blank flag are registered.
  - T+2: RAM data is available.
  - T+3: scaled row and blank are registered.
- Back-to-back `rd_req` every cycle is supported at full throughput. There is no backpressure.
- Write-to-read visibility: a sample written at cycle W is visible only after the next `frame_start` that follows W.
- Reset values (all outputs are 0 during reset and in the cycle after reset is released):
  - `rd_valid`=0, `rd_row`=0, `rd_blank`=0, `full`=0.
  - All internal pipeline valid bits are cleared.
- If reset is asserted mid-pipeline, in-flight reads are dropped and produce no `rd_valid`.

## Structure
- **Package `roll_pkg`:**
  - `DEPTH`, `SAMPLE_W`, `ROWS` defaults.
  - `COL_W`=10, `ROW_W`=9.
  - The sample, column and row typedefs.
  - The scaling function.
- **Sub-module `roll_sample_ram`:** parameterised simple dual-port, read-first, registered-read RAM. It must infer block RAM.
- **Top level:** the pointer/count logic, the frame latch, and the 3-stage read pipeline.

## Test plan
- **Reset then frame read.** Reset, pulse `frame_start`, read columns 0..639. Required: every response has `rd_blank`=1 and `rd_row`=0, and `full`=0.
- **Partial fill.** Write 3 samples: 0, 2048, 4095. Pulse `frame_start`, read columns 636..639. Required:
  - Column 636 is blank.
  - Columns 637, 638, 639 give `rd_row` = 479, 239, 0.
  - Each response arrives exactly 3 cycles after its request.
- **Wrap-around.** Write 700 samples with value = index mod 4096. Pulse `frame_start`. Required:
  - `full`=1.
  - Column 0 holds sample 60; column 639 holds sample 699, with rows computed by the scaling formula.
- **Freeze.** Set `freeze`=1 and issue 10 strobes of value 4095. Pulse `frame_start`. Required: the frame is identical to the previous frame.
- **Tear-free frame.** Write during a frame read, and make a write and `frame_start` coincide. Required:
  - Reads until the next `frame_start` reflect the old `base`.
  - The coincident write appears only in the following frame.
- **Reset mid-burst.** Assert `rst_n`=0 at T+1 of a read burst. Required: no `rd_valid` for any in-flight request, and `count`=0 afterwards.

Source files
------------

// File: rtl/roll_pkg.sv
// Shared constants, types and the sample-to-row scaling used by the roll-mode display buffer.
package roll_pkg;

  localparam int DEPTH_DEF    = 640;
  localparam int SAMPLE_W_DEF = 12;
  localparam int ROWS_DEF     = 480;
  localparam int COL_W        = 10;
  localparam int ROW_W        = 9;
  localparam int PROD_W       = SAMPLE_W_DEF + COL_W;

  typedef logic [SAMPLE_W_DEF-1:0] sample_t;
  typedef logic [COL_W-1:0]        col_t;
  typedef logic [ROW_W-1:0]        row_t;

  // Full scale is drawn at the top, so the sample is inverted before scaling to the row count.
  function automatic row_t scale_row(input sample_t sample, input col_t rows);
    logic [SAMPLE_W_DEF-1:0] inv;
    logic [PROD_W-1:0]       prod;
    inv  = ~sample;
    prod = PROD_W'(inv) * PROD_W'(rows);
    return row_t'(prod >> SAMPLE_W_DEF);
  endfunction

endpackage

// File: rtl/roll_sample_ram.sv
// Simple dual-port, read-first sample store with a registered read port.
module roll_sample_ram #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 12,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both ports update on the same edge, so a same-slot read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/roll_display_buffer.sv
// Circular column buffer behind the roll decimator: frame-latched base, right-aligned
// partial fill, and a fixed 3-cycle column read pipeline that returns a screen row.
module roll_display_buffer
  import roll_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ROWS     = ROWS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_we,
  input  logic                freeze,
  input  logic                frame_start,
  input  logic                rd_req,
  input  logic [COL_W-1:0]    rd_col,
  output logic                rd_valid,
  output logic [ROW_W-1:0]    rd_row,
  output logic                rd_blank,
  output logic                full
);

  localparam logic [COL_W:0] DEPTH_C = (COL_W+1)'(DEPTH);
  localparam col_t           LAST    = col_t'(DEPTH - 1);

  col_t             wr_ptr;
  col_t             base;
  logic [COL_W:0]   count;
  logic [COL_W:0]   fcount;
  logic             wr_en;

  logic [COL_W:0]   sum;
  logic             col_beyond;
  col_t             addr_c;
  logic             blank_c;

  logic             vld_p0, vld_p1, vld_p2;
  col_t             addr_p0;
  logic             blank_p0, blank_p1, blank_p2;
  logic [SAMPLE_W-1:0] rdata_p1;
  row_t             row_p2;

  assign wr_en = sample_we & ~freeze;
  assign full  = (count == DEPTH_C);

  // Write pointer, fill count and the per-frame snapshot of both; the snapshot takes pre-write values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
      base   <= '0;
      fcount <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + col_t'(1);
        if (count != DEPTH_C) count <= count + (COL_W+1)'(1);
      end
      if (frame_start) begin
        base   <= wr_ptr;
        fcount <= count;
      end
    end
  end

  // Columns left of DEPTH-fcount have no sample yet, which right-aligns a partial buffer.
  always_comb begin
    sum        = {1'b0, base} + {1'b0, rd_col};
    col_beyond = ({1'b0, rd_col} >= DEPTH_C);
    blank_c    = col_beyond | ({1'b0, rd_col} < (DEPTH_C - fcount));
    addr_c     = '0;
    if (!col_beyond) begin
      addr_c = (sum >= DEPTH_C) ? col_t'(sum - DEPTH_C) : col_t'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= rd_req;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage p0: registered RAM address and blank flag
  always_ff @(posedge clk) begin
    addr_p0  <= addr_c;
    blank_p0 <= blank_c;
  end

  // Stage p1: RAM word
  roll_sample_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W),
    .ADDR_W(COL_W)
  ) u_ram (
    .clk    (clk),
    .we     (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(sample_in),
    .re     (vld_p0),
    .rd_addr(addr_p0),
    .rd_data(rdata_p1)
  );

  always_ff @(posedge clk) begin
    blank_p1 <= blank_p0;
  end

  // Stage p2: scaled row
  always_ff @(posedge clk) begin
    row_p2   <= blank_p1 ? '0 : scale_row(rdata_p1, col_t'(ROWS));
    blank_p2 <= blank_p1;
  end

  assign rd_valid = vld_p2;
  assign rd_row   = vld_p2 ? row_p2 : '0;
  assign rd_blank = vld_p2 & blank_p2;

endmodule

// File: tb/tb_roll_display_buffer.sv
// Directed bench for roll_display_buffer: fill, wrap, freeze, frame tearing and reset behaviour.
module tb_roll_display_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [11:0] sample_in = '0;
  logic       sample_we = 1'b0;
  logic       freeze = 1'b0;
  logic       frame_start = 1'b0;
  logic       rd_req = 1'b0;
  logic [9:0] rd_col = '0;
  logic       rd_valid;
  logic [8:0] rd_row;
  logic       rd_blank;
  logic       full;

  int checks = 0;
  int errors = 0;

  logic       got_v [0:1023];
  logic [8:0] got_r [0:1023];
  logic       got_b [0:1023];

  always #5 clk = ~clk;

  roll_display_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_in  (sample_in),
    .sample_we  (sample_we),
    .freeze     (freeze),
    .frame_start(frame_start),
    .rd_req     (rd_req),
    .rd_col     (rd_col),
    .rd_valid   (rd_valid),
    .rd_row     (rd_row),
    .rd_blank   (rd_blank),
    .full       (full)
  );

  function automatic logic [8:0] ref_row(input int s);
    return 9'(((4095 - s) * 480) / 4096);
  endfunction

  task automatic apply_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_sample(input int v);
    sample_we = 1'b1;
    sample_in = 12'(v);
    @(posedge clk); #1;
    sample_we = 1'b0;
  endtask

  task automatic frame_pulse;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Request i shows up in got_*[i+2] (three cycles after the request cycle).
  task automatic do_burst(input int first, input int n, input int wr_at, input int wr_val,
                          input int fs_at);
    for (int i = 0; i < n + 4; i++) begin
      rd_req      = (i < n);
      rd_col      = (i < n) ? 10'(first + i) : '0;
      sample_we   = (i == wr_at);
      sample_in   = 12'(wr_val);
      frame_start = (i == fs_at);
      @(posedge clk); #1;
      got_v[i] = rd_valid;
      got_r[i] = rd_row;
      got_b[i] = rd_blank;
    end
    rd_req = 1'b0;
    sample_we = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rd_valid, rd_row, rd_blank, full} !== 12'b0) begin
        errors++;
        $display("FAIL reset_outputs got %b want 0", {rd_valid, rd_row, rd_blank, full});
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rd_valid, rd_row, rd_blank, full} !== 12'b0) begin
      errors++;
      $display("FAIL post_reset_outputs got %b want 0", {rd_valid, rd_row, rd_blank, full});
    end
  endtask

  task automatic test_empty_frame;
    int bad;
    bad = 0;
    frame_pulse();
    do_burst(0, 640, -1, 0, -1);
    for (int c = 0; c < 640; c++) begin
      checks++;
      if (got_v[c+2] !== 1'b1 || got_b[c+2] !== 1'b1 || got_r[c+2] !== 9'd0) begin
        errors++;
        if (bad < 5)
          $display("FAIL empty_col%0d got v=%b b=%b row=%0d want v=1 b=1 row=0",
                   c, got_v[c+2], got_b[c+2], got_r[c+2]);
        bad++;
      end
    end
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL empty_full got %b want 0", full);
    end
  endtask

  task automatic test_partial_fill;
    logic [8:0] exp_r [0:3];
    logic       exp_b [0:3];
    exp_r[0] = 9'd0;   exp_b[0] = 1'b1;
    exp_r[1] = 9'd479; exp_b[1] = 1'b0;
    exp_r[2] = 9'd239; exp_b[2] = 1'b0;
    exp_r[3] = 9'd0;   exp_b[3] = 1'b0;
    apply_reset();
    write_sample(0);
    write_sample(2048);
    write_sample(4095);
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL partial_full got %b want 0", full);
    end
    frame_pulse();
    do_burst(636, 4, -1, 0, -1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_v[k] !== ((k >= 2) && (k < 6))) begin
        errors++;
        $display("FAIL partial_latency slot%0d got %b want %b", k, got_v[k], (k >= 2) && (k < 6));
      end
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (got_r[c+2] !== exp_r[c] || got_b[c+2] !== exp_b[c]) begin
        errors++;
        $display("FAIL partial_col%0d got row=%0d blank=%b want row=%0d blank=%b",
                 636 + c, got_r[c+2], got_b[c+2], exp_r[c], exp_b[c]);
      end
    end
  endtask

  task automatic check_wrapped_frame(input string tag);
    int bad;
    bad = 0;
    do_burst(0, 640, -1, 0, -1);
    for (int c = 0; c < 640; c++) begin
      checks++;
      if (got_v[c+2] !== 1'b1 || got_b[c+2] !== 1'b0 || got_r[c+2] !== ref_row(60 + c)) begin
        errors++;
        if (bad < 5)
          $display("FAIL %s_col%0d got v=%b b=%b row=%0d want v=1 b=0 row=%0d",
                   tag, c, got_v[c+2], got_b[c+2], got_r[c+2], ref_row(60 + c));
        bad++;
      end
    end
    checks++;
    if (got_r[2] !== 9'd472 || got_r[641] !== 9'd397) begin
      errors++;
      $display("FAIL %s_edges got %0d/%0d want 472/397", tag, got_r[2], got_r[641]);
    end
  endtask

  task automatic test_wrap;
    apply_reset();
    for (int i = 0; i < 700; i++) write_sample(i % 4096);
    frame_pulse();
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full got %b want 1", full);
    end
    check_wrapped_frame("wrap");
  endtask

  task automatic test_freeze;
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) write_sample(4095);
    frame_pulse();
    freeze = 1'b0;
    check_wrapped_frame("freeze");
  endtask

  task automatic test_tear_free;
    // Write lands in slot 60 while columns 637..639 are read against base 60.
    do_burst(637, 3, 1, 4095, -1);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (got_r[c+2] !== ref_row(697 + c) || got_b[c+2] !== 1'b0) begin
        errors++;
        $display("FAIL tear_during_col%0d got %0d want %0d", 637 + c, got_r[c+2], ref_row(697 + c));
      end
    end
    do_burst(639, 1, -1, 0, -1);
    checks++;
    if (got_r[2] !== 9'd397) begin
      errors++;
      $display("FAIL tear_old_base got %0d want 397", got_r[2]);
    end
    do_burst(0, 0, 0, 0, 0);
    do_burst(638, 2, -1, 0, -1);
    checks++;
    if (got_r[2] !== 9'd397 || got_r[3] !== 9'd0) begin
      errors++;
      $display("FAIL tear_coincident got %0d/%0d want 397/0", got_r[2], got_r[3]);
    end
    frame_pulse();
    do_burst(638, 2, -1, 0, -1);
    checks++;
    if (got_r[2] !== 9'd0 || got_r[3] !== 9'd479) begin
      errors++;
      $display("FAIL tear_next_frame got %0d/%0d want 0/479", got_r[2], got_r[3]);
    end
  endtask

  task automatic test_reset_mid_burst;
    int seen;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      rd_req = (i < 2);
      rd_col = 10'(639 - i);
      rst_n  = !((i >= 1) && (i < 4));
      @(posedge clk); #1;
      if (rd_valid === 1'b1) seen++;
    end
    rd_req = 1'b0;
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_valid got %0d responses want 0", seen);
    end
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL midreset_full got %b want 0", full);
    end
    write_sample(1000);
    frame_pulse();
    do_burst(638, 2, -1, 0, -1);
    checks++;
    if (got_b[2] !== 1'b1 || got_r[2] !== 9'd0) begin
      errors++;
      $display("FAIL midreset_col638 got blank=%b row=%0d want 1/0", got_b[2], got_r[2]);
    end
    checks++;
    if (got_b[3] !== 1'b0 || got_r[3] !== 9'd362) begin
      errors++;
      $display("FAIL midreset_col639 got blank=%b row=%0d want 0/362", got_b[3], got_r[3]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_empty_frame();
    test_partial_fill();
    test_wrap();
    test_freeze();
    test_tear_free();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
